// File: rtl/cv32e40p_irq_arbiter.sv
// cv32e40p_irq_arbiter
// Per-source interrupt controller feeding the CV32E40P irq_i/irq_level_i/irq_shv_i
// inputs. Each source has enable, pending, trigger mode, shv and an 8-bit level.
// A threshold register masks low levels. The highest level candidate wins, and ties
// go to the highest index. A simple req/gnt/rvalid bus gives access to the registers.
module cv32e40p_irq_arbiter #(
  parameter  int NUM_INTERRUPTS = 32,
  localparam int ID_W           = (NUM_INTERRUPTS > 1) ? $clog2(NUM_INTERRUPTS) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_INTERRUPTS-1:0] src_i,
  input  logic                      cfg_req_i,
  output logic                      cfg_gnt_o,
  input  logic                      cfg_we_i,
  input  logic [11:0]               cfg_addr_i,
  input  logic [31:0]               cfg_wdata_i,
  output logic                      cfg_rvalid_o,
  output logic [31:0]               cfg_rdata_o,
  output logic [NUM_INTERRUPTS-1:0] irq_o,
  output logic [7:0]                irq_level_o,
  output logic                      irq_shv_o,
  input  logic                      irq_ack_i,
  input  logic [ID_W-1:0]           irq_id_i
);

  // Per-source state
  logic [NUM_INTERRUPTS-1:0] r_src_q;
  logic [NUM_INTERRUPTS-1:0] r_ie;
  logic [NUM_INTERRUPTS-1:0] r_ip;
  logic [NUM_INTERRUPTS-1:0] r_trig;
  logic [NUM_INTERRUPTS-1:0] r_shv;
  logic [7:0]                r_level [NUM_INTERRUPTS];
  logic [7:0]                r_thresh;

  // Bus response and registered arbiter outputs
  logic                      r_rvalid;
  logic [31:0]               r_rdata;
  logic [NUM_INTERRUPTS-1:0] r_irq;
  logic [7:0]                r_irq_level;
  logic                      r_irq_shv;

  // Decode, event and arbitration wires
  logic [8:0]                w_word;
  logic                      w_wr;
  logic                      w_thr_hit;
  logic [NUM_INTERRUPTS-1:0] w_sel;
  logic [NUM_INTERRUPTS-1:0] w_src_we;
  logic [NUM_INTERRUPTS-1:0] w_ack;
  logic [NUM_INTERRUPTS-1:0] w_edge;
  logic [NUM_INTERRUPTS-1:0] w_ip_nxt;
  logic [NUM_INTERRUPTS-1:0] w_cand;
  logic [31:0]               w_rdata;
  logic                      w_found;
  logic [7:0]                w_win_lvl;
  logic                      w_win_shv;
  logic [NUM_INTERRUPTS-1:0] w_win_onehot;
  logic                      w_unused_bits;

  // Byte-address bits [1:0] and the upper write-data half have no register behind them.
  assign w_unused_bits = ^{cfg_addr_i[1:0], cfg_wdata_i[31:16]};

  // The bus never stalls.
  assign cfg_gnt_o    = cfg_req_i;
  assign w_word       = cfg_addr_i[10:2];
  assign w_wr         = cfg_req_i & cfg_we_i;
  assign w_thr_hit    = (cfg_addr_i[11:2] == 10'h200);
  assign w_edge       = src_i & ~r_src_q;

  assign cfg_rvalid_o = r_rvalid;
  assign cfg_rdata_o  = r_rdata;
  assign irq_o        = r_irq;
  assign irq_level_o  = r_irq_level;
  assign irq_shv_o    = r_irq_shv;

  // Per-source address select, write enable and ack match; out-of-range words and ids match nothing
  always_comb begin
    w_sel    = '0;
    w_src_we = '0;
    w_ack    = '0;
    for (int i = 0; i < NUM_INTERRUPTS; i++) begin
      w_sel[i]    = ~cfg_addr_i[11] & (w_word == 9'(i));
      w_src_we[i] = w_wr & w_sel[i];
      w_ack[i]    = irq_ack_i & (irq_id_i == ID_W'(i));
    end
  end

  // Next pending bit: level sources follow the input, edge sources use write > edge > ack
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_ip_nxt = r_ip;
    for (int i = 0; i < NUM_INTERRUPTS; i++) begin
      if (!r_trig[i])        w_ip_nxt[i] = src_i[i];
      else if (w_src_we[i])  w_ip_nxt[i] = cfg_wdata_i[1];
      else if (w_edge[i])    w_ip_nxt[i] = 1'b1;
      else if (w_ack[i])     w_ip_nxt[i] = 1'b0;
    end
  end

  // Read mux; unmapped addresses read as zero
  always_comb begin
    w_rdata = '0;
    if (w_thr_hit) w_rdata[7:0] = r_thresh;
    for (int i = 0; i < NUM_INTERRUPTS; i++) begin
      if (w_sel[i]) begin
        w_rdata[0]    = r_ie[i];
        w_rdata[1]    = r_ip[i];
        w_rdata[2]    = r_trig[i];
        w_rdata[3]    = r_shv[i];
        w_rdata[15:8] = r_level[i];
      end
    end
  end

  // Arbitration: highest level wins, ">=" while scanning upward hands ties to the higher index
  always_comb begin
    w_cand       = '0;
    w_found      = 1'b0;
    w_win_lvl    = '0;
    w_win_shv    = 1'b0;
    w_win_onehot = '0;
    for (int i = 0; i < NUM_INTERRUPTS; i++) begin
      w_cand[i] = r_ie[i] & r_ip[i] & (r_level[i] > r_thresh);
      if (w_cand[i] && (!w_found || (r_level[i] >= w_win_lvl))) begin
        w_found         = 1'b1;
        w_win_lvl       = r_level[i];
        w_win_shv       = r_shv[i];
        w_win_onehot    = '0;
        w_win_onehot[i] = 1'b1;
      end
    end
  end

  // Source sampling and pending-bit state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_src_q <= '0;
      r_ip    <= '0;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
      r_src_q <= src_i;
      r_ip    <= w_ip_nxt;
    end
  end

  // Software-visible configuration fields
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ie     <= '0;
      r_trig   <= '0;
      r_shv    <= '0;
      r_thresh <= '0;
      // NOTE: the level array is a bank of flops, not RAM, so it can and must clear on reset.
      for (int i = 0; i < NUM_INTERRUPTS; i++) r_level[i] <= '0;
    end else begin
      if (w_wr && w_thr_hit) r_thresh <= cfg_wdata_i[7:0];
      for (int i = 0; i < NUM_INTERRUPTS; i++) begin
        if (w_src_we[i]) begin
          r_ie[i]    <= cfg_wdata_i[0];
          r_trig[i]  <= cfg_wdata_i[2];
          r_shv[i]   <= cfg_wdata_i[3];
          r_level[i] <= cfg_wdata_i[15:8];
        end
      end
    end
  end

  // One-cycle bus response carrying pre-write register contents (zero for writes)
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= cfg_req_i;
      r_rdata  <= (cfg_req_i && !cfg_we_i) ? w_rdata : '0;
    end
  end

  // Registered winner towards the core
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_irq       <= '0;
      r_irq_level <= '0;
      r_irq_shv   <= 1'b0;
    end else begin
      r_irq       <= w_win_onehot;
      r_irq_level <= w_win_lvl;
      r_irq_shv   <= w_win_shv;
    end
  end

endmodule

// File: tb/tb_cv32e40p_irq_arbiter.sv
// Self-checking bench for cv32e40p_irq_arbiter (NUM_INTERRUPTS = 32).
// Bus responses are checked through a scoreboard queue; arbitration through a vector table;
// latency, ack, priority and reset corners through short hand-written sequences.
module tb_cv32e40p_irq_arbiter;

  localparam int N = 32;

  logic          clk;
  logic          rst_ni;
  logic [N-1:0]  src_i;
  logic          cfg_req_i;
  logic          cfg_gnt_o;
  logic          cfg_we_i;
  logic [11:0]   cfg_addr_i;
  logic [31:0]   cfg_wdata_i;
  logic          cfg_rvalid_o;
  logic [31:0]   cfg_rdata_o;
  logic [N-1:0]  irq_o;
  logic [7:0]    irq_level_o;
  logic          irq_shv_o;
  logic          irq_ack_i;
  logic [4:0]    irq_id_i;

  cv32e40p_irq_arbiter #(.NUM_INTERRUPTS(N)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .src_i        (src_i),
    .cfg_req_i    (cfg_req_i),
    .cfg_gnt_o    (cfg_gnt_o),
    .cfg_we_i     (cfg_we_i),
    .cfg_addr_i   (cfg_addr_i),
    .cfg_wdata_i  (cfg_wdata_i),
    .cfg_rvalid_o (cfg_rvalid_o),
    .cfg_rdata_o  (cfg_rdata_o),
    .irq_o        (irq_o),
    .irq_level_o  (irq_level_o),
    .irq_shv_o    (irq_shv_o),
    .irq_ack_i    (irq_ack_i),
    .irq_id_i     (irq_id_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Cycle counter used to time-stamp expected bus responses
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    int unsigned cyc;
  } rsp_t;
  rsp_t sb[$];
  rsp_t sb_head;

  typedef struct {
    logic [31:0] src;
    logic [7:0]  thresh;
    logic [31:0] exp_irq;
    logic [7:0]  exp_lvl;
    logic        exp_shv;
  } vec_t;
  vec_t vecs[12];

  logic [7:0] lv [8];
  logic       sh [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_out(input string name, input logic [31:0] e_irq,
                           input logic [7:0] e_lvl, input logic e_shv);
    check({name, "_irq"}, irq_o, e_irq);
    check({name, "_lvl"}, 32'(irq_level_o), 32'(e_lvl));
    check({name, "_shv"}, 32'(irq_shv_o), 32'(e_shv));
  endtask

  // Advance n cycles; inputs change and outputs are sampled 1 time unit after the edge
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [11:0] addr, input logic [31:0] data);
    cfg_req_i   = 1'b1;
    cfg_we_i    = 1'b1;
    cfg_addr_i  = addr;
    cfg_wdata_i = data;
    sb.push_back('{data: 32'h0, cyc: cyc + 1});
    tick(1);
    cfg_req_i = 1'b0;
    cfg_we_i  = 1'b0;
  endtask

  task automatic bus_read(input logic [11:0] addr, input logic [31:0] exp);
    cfg_req_i  = 1'b1;
    cfg_we_i   = 1'b0;
    cfg_addr_i = addr;
    sb.push_back('{data: exp, cyc: cyc + 1});
    #1;
    check("gnt", 32'(cfg_gnt_o), 32'h1);
    @(posedge clk);
    #1;
    cfg_req_i = 1'b0;
  endtask

  // Scoreboard: each request expects exactly one rvalid, in the following cycle
  always @(negedge clk) begin
    if (rst_ni) begin
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        sb_head = sb.pop_front();
        check("rvalid", 32'(cfg_rvalid_o), 32'h1);
        check("rdata", cfg_rdata_o, sb_head.data);
      end else if (cfg_rvalid_o) begin
        check("rvalid_extra", 32'(cfg_rvalid_o), 32'h0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Arbitration vectors: sources 0..7 are level mode with the levels below
    lv = '{8'd3, 8'd7, 8'd7, 8'd1, 8'd9, 8'd0, 8'd2, 8'd7};
    sh = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[0]  = '{32'h0000_0000, 8'd0, 32'h0000_0000, 8'd0, 1'b0};
    vecs[1]  = '{32'h0000_0001, 8'd0, 32'h0000_0001, 8'd3, 1'b0};
    vecs[2]  = '{32'h0000_0006, 8'd0, 32'h0000_0004, 8'd7, 1'b1};
    vecs[3]  = '{32'h0000_0086, 8'd0, 32'h0000_0080, 8'd7, 1'b0};
    vecs[4]  = '{32'h0000_0096, 8'd0, 32'h0000_0010, 8'd9, 1'b0};
    vecs[5]  = '{32'h0000_0020, 8'd0, 32'h0000_0000, 8'd0, 1'b0};
    vecs[6]  = '{32'h0000_0009, 8'd2, 32'h0000_0001, 8'd3, 1'b0};
    vecs[7]  = '{32'h0000_0009, 8'd3, 32'h0000_0000, 8'd0, 1'b0};
    vecs[8]  = '{32'h0000_00FF, 8'd8, 32'h0000_0010, 8'd9, 1'b0};
    vecs[9]  = '{32'h0000_00FF, 8'd9, 32'h0000_0000, 8'd0, 1'b0};
    vecs[10] = '{32'h0000_0048, 8'd0, 32'h0000_0040, 8'd2, 1'b0};
    vecs[11] = '{32'hFFFF_FF00, 8'd0, 32'h0000_0000, 8'd0, 1'b0};

    rst_ni      = 1'b0;
    src_i       = '0;
    cfg_req_i   = 1'b0;
    cfg_we_i    = 1'b0;
    cfg_addr_i  = '0;
    cfg_wdata_i = '0;
    irq_ack_i   = 1'b0;
    irq_id_i    = '0;

    // Reset state
    tick(2);
    check_out("reset", 32'h0, 8'd0, 1'b0);
    check("reset_rvalid", 32'(cfg_rvalid_o), 32'h0);
    check("reset_rdata", cfg_rdata_o, 32'h0);
    check("reset_gnt", 32'(cfg_gnt_o), 32'h0);
    rst_ni = 1'b1;
    tick(2);

    // Configuration and register map
    for (int i = 0; i < 8; i++)
      bus_write(12'(4 * i), {16'h0, lv[i], 4'h0, sh[i], 3'b001});
    bus_read(12'h008, 32'h0000_0709);
    bus_read(12'h00B, 32'h0000_0709);
    bus_read(12'h010, 32'h0000_0901);
    bus_write(12'h800, 32'hFFFF_FFFF);
    bus_read(12'h800, 32'h0000_00FF);
    bus_read(12'h7FC, 32'h0);
    bus_write(12'h7FC, 32'hFFFF_FFFF);
    bus_read(12'h7FC, 32'h0);
    bus_read(12'h804, 32'h0);

    // Table-driven arbitration
    for (int k = 0; k < 12; k++) begin
      bus_write(12'h800, {24'h0, vecs[k].thresh});
      src_i = vecs[k].src;
      tick(3);
      check_out($sformatf("vec%0d", k), vecs[k].exp_irq, vecs[k].exp_lvl, vecs[k].exp_shv);
      check($sformatf("vec%0d_onehot", k), 32'($countones(irq_o) <= 1), 32'h1);
    end

    // Asynchronous reset in the middle of a response with an interrupt asserted
    bus_write(12'h800, 32'h0);
    src_i = 32'h0000_00FF;
    tick(3);
    check_out("pre_rst", 32'h10, 8'd9, 1'b0);
    cfg_req_i  = 1'b1;
    cfg_we_i   = 1'b0;
    cfg_addr_i = 12'h010;
    @(posedge clk);
    #1;
    check("pre_rst_rvalid", 32'(cfg_rvalid_o), 32'h1);
    check("pre_rst_rdata", cfg_rdata_o, 32'h0000_0903);
    #1;
    rst_ni = 1'b0;
    #1;
    check_out("mid_rst", 32'h0, 8'd0, 1'b0);
    check("mid_rst_rvalid", 32'(cfg_rvalid_o), 32'h0);
    check("mid_rst_rdata", cfg_rdata_o, 32'h0);
    tick(1);
    check("in_rst_rvalid", 32'(cfg_rvalid_o), 32'h0);
    cfg_req_i = 1'b0;
    src_i     = '0;
    rst_ni    = 1'b1;
    tick(1);
    check("post_rst_rvalid", 32'(cfg_rvalid_o), 32'h0);
    check_out("post_rst", 32'h0, 8'd0, 1'b0);
    tick(1);

    // Edge source 3: latency of two cycles, wrong-id ack ignored, ack drops it
    bus_write(12'h00C, 32'h0000_0505);
    src_i[3] = 1'b1;
    tick(1);
    src_i[3] = 1'b0;
    check_out("edge_n1", 32'h0, 8'd0, 1'b0);
    tick(1);
    check_out("edge_n2", 32'h8, 8'd5, 1'b0);
    irq_ack_i = 1'b1;
    irq_id_i  = 5'd2;
    tick(1);
    irq_ack_i = 1'b0;
    check_out("wrong_ack", 32'h8, 8'd5, 1'b0);
    tick(1);
    irq_ack_i = 1'b1;
    irq_id_i  = 5'd3;
    tick(1);
    irq_ack_i = 1'b0;
    check_out("ack_p1", 32'h8, 8'd5, 1'b0);
    tick(1);
    check_out("ack_p2", 32'h0, 8'd0, 1'b0);
    bus_read(12'h00C, 32'h0000_0505);

    // Equal levels go to the higher index; raising source 2 takes over two cycles later
    bus_write(12'h008, 32'h0000_0405);
    bus_write(12'h008, 32'h0000_0407);
    bus_write(12'h01C, 32'h0000_0405);
    bus_write(12'h01C, 32'h0000_0407);
    tick(2);
    check_out("tie", 32'h80, 8'd4, 1'b0);
    bus_write(12'h008, 32'h0000_0907);
    check_out("raise_n1", 32'h80, 8'd4, 1'b0);
    tick(1);
    check_out("raise_n2", 32'h04, 8'd9, 1'b0);

    // Threshold is strict: level equal to thresh is not a candidate
    bus_write(12'h008, 32'h0);
    bus_write(12'h01C, 32'h0);
    bus_write(12'h014, 32'h0000_0505);
    bus_write(12'h014, 32'h0000_0507);
    bus_write(12'h800, 32'h0000_0005);
    tick(2);
    check_out("thr_eq", 32'h0, 8'd0, 1'b0);
    bus_write(12'h014, 32'h0000_0607);
    check_out("thr_gt_n1", 32'h0, 8'd0, 1'b0);
    tick(1);
    check_out("thr_gt_n2", 32'h20, 8'd6, 1'b0);

    // Level source 0 ignores ack and follows its input
    bus_write(12'h014, 32'h0);
    bus_write(12'h800, 32'h0);
    bus_write(12'h000, 32'h0000_0101);
    src_i[0] = 1'b1;
    tick(2);
    check_out("lvl_on", 32'h1, 8'd1, 1'b0);
    irq_ack_i = 1'b1;
    irq_id_i  = 5'd0;
    tick(1);
    irq_ack_i = 1'b0;
    tick(2);
    check_out("lvl_ack", 32'h1, 8'd1, 1'b0);
    src_i[0] = 1'b0;
    tick(1);
    check_out("lvl_off_n1", 32'h1, 8'd1, 1'b0);
    tick(1);
    check_out("lvl_off_n2", 32'h0, 8'd0, 1'b0);

    // Source 4 edge mode: write beats edge beats ack
    bus_write(12'h010, 32'h0000_0105);
    bus_write(12'h010, 32'h0000_0107);
    tick(2);
    check_out("src4_on", 32'h10, 8'd1, 1'b0);
    src_i[4]  = 1'b1;
    irq_ack_i = 1'b1;
    irq_id_i  = 5'd4;
    bus_write(12'h010, 32'h0000_0105);
    src_i[4]  = 1'b0;
    irq_ack_i = 1'b0;
    bus_read(12'h010, 32'h0000_0105);
    check_out("wr_wins", 32'h0, 8'd0, 1'b0);
    src_i[4]  = 1'b1;
    irq_ack_i = 1'b1;
    irq_id_i  = 5'd4;
    tick(1);
    irq_ack_i = 1'b0;
    bus_read(12'h010, 32'h0000_0107);
    check_out("edge_wins", 32'h10, 8'd1, 1'b0);

    tick(3);
    check("sb_empty", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cv32e40p_irq_arbiter.md
CV32E40P_IRQ_ARBITER -- requirements
Module: cv32e40p_irq_arbiter

Interface
REQ-001 SHALL have parameter NUM_INTERRUPTS, default 32, meaning number of interrupt sources and width of irq_o (legal range 1..32).
REQ-002 SHALL have port clk_i  input  1  core clock; one clock domain only.
REQ-003 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port src_i  input  NUM_INTERRUPTS  raw interrupt sources, synchronous to clk_i.
REQ-005 SHALL have port cfg_req_i  input  1  config bus request.
REQ-006 SHALL have port cfg_gnt_o  output  1  config bus grant.
REQ-007 SHALL have port cfg_we_i  input  1  1 = write, 0 = read.
REQ-008 SHALL have port cfg_addr_i  input  12  byte address, word aligned; bits [1:0] are ignored.
REQ-009 SHALL have port cfg_wdata_i  input  32  write data.
REQ-010 SHALL have port cfg_rvalid_o  output  1  response valid.
REQ-011 SHALL have port cfg_rdata_o  output  32  read data; 0 when the response is to a write.
REQ-012 SHALL have port irq_o  output  NUM_INTERRUPTS  one-hot selected interrupt, drives core irq_i.
REQ-013 SHALL have port irq_level_o  output  8  level of the selected interrupt, drives core irq_level_i.
REQ-014 SHALL have port irq_shv_o  output  1  selective hardware vectoring flag of the selected interrupt, drives core irq_shv_i.
REQ-015 SHALL have port irq_ack_i  input  1  core interrupt acknowledge.
REQ-016 SHALL have port irq_id_i  input  $clog2(NUM_INTERRUPTS)  id of the interrupt acknowledged by the core.

Function
REQ-017 SHALL provide one control register per source i, at address 4*i: bit0 ie (enable), bit1 ip (pending), bit2 trig (0 = level, 1 = rising edge), bit3 shv, bits[15:8] level; all other bits read 0.
REQ-018 SHALL provide a threshold register at address 0x800: bits[7:0] thresh; all other bits read 0.
REQ-019 SHALL complete reads of unmapped addresses (source index >= NUM_INTERRUPTS, or any other address) with rdata 0, and SHALL ignore writes to them; no error response.
REQ-020 SHALL drive cfg_gnt_o = cfg_req_i combinationally.
REQ-021 SHALL assert cfg_rvalid_o for exactly one cycle, in the cycle after each granted request.
REQ-022 SHALL return in cfg_rdata_o the register contents sampled in the grant cycle; the value written by a write in the same cycle is not visible to that read.
REQ-023 SHALL update register writes at the clock edge that ends the grant cycle.
REQ-024 SHALL register src_i into src_q every cycle.
REQ-025 SHALL, for an edge-mode source, set ip when src_i & ~src_q.
REQ-026 SHALL, for a level-mode source, make ip track src_q; software writes to ip of a level-mode source are ignored.
REQ-027 SHALL, for an edge-mode source, clear ip when irq_ack_i = 1 and irq_id_i == i; ack has no effect on level-mode sources.
REQ-028 SHALL resolve simultaneous events on one edge-mode ip with priority: software write > new edge > ack.
REQ-029 SHALL treat a source as a candidate when ie & ip & (level > thresh).
REQ-030 SHALL select, among candidates, the highest level; ties go to the highest index.
REQ-031 SHALL register its outputs: irq_o = one-hot of the winner, irq_level_o = winner level, irq_shv_o = winner shv.
REQ-032 SHALL drive irq_o = 0, irq_level_o = 0 and irq_shv_o = 0 when there are no candidates.
REQ-033 SHALL have this latency: src_i rising at cycle n -> ip = 1 at n+1 -> irq_o valid at n+2.
REQ-034 SHALL have this latency: a config write in cycle n is reflected in the outputs at n+2.
REQ-035 SHALL drop an acknowledged edge interrupt from irq_o no later than 2 cycles after the ack, unless it was re-pended.
REQ-036 SHALL ignore irq_id_i values >= NUM_INTERRUPTS.
REQ-037 SHALL never assert more than one bit of irq_o in any cycle.

Reset
REQ-038 SHALL, while rst_ni = 0, asynchronously clear src_q, all ie/ip/trig/shv/level fields, thresh, cfg_rvalid_o, cfg_rdata_o, irq_o, irq_level_o and irq_shv_o.
REQ-039 SHALL, after reset release, require 2 cycles before any irq_o assertion is possible; a bus request pending when reset asserts is dropped with no rvalid.

Verification
REQ-040 SHALL cover: source 3 edge mode, ie = 1, level 5, thresh 0; src_i[3] pulses at cycle 10 -> irq_o = 0x8, level 5 at cycle 12; ack id 3 at cycle 15 -> irq_o = 0 by cycle 17.
REQ-041 SHALL cover: sources 2 and 7 pending, both level 4 -> irq_o selects 7; raise source 2 to level 9 -> irq_o = 0x4 two cycles after the write.
REQ-042 SHALL cover: thresh = 5, candidate at level 5 -> irq_o = 0; candidate at level 6 -> asserted.
REQ-043 SHALL cover: level-mode source 0 held high, then ack id 0 -> irq_o stays 0x1; src_i[0] dropped -> irq_o = 0 two cycles later.
REQ-044 SHALL cover: write ip = 0, a new edge and an ack all on source 4 in the same cycle -> ip reads 0; then an edge plus an ack in the same cycle -> ip reads 1.
REQ-045 SHALL cover: read of address 0x7FC with NUM_INTERRUPTS = 32 -> rdata 0, one rvalid; rst_ni asserted mid-operation -> all outputs 0 in the same cycle.
